mem_access_ctrl: RTL and testbench

- MEM-stage controller between the pipeline and a word-addressed data memory with a valid/ready request channel and variable-latency read response.
- Generates byte write enables and lane-replicated store data.
- Stalls the pipeline until the access completes.
- Registers the returned load word and the byte offset consumed by the downstream load-extension stage.

---
 rtl/mem_access_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: issues one valid/ready request per
// load/store, stalls the pipeline until it completes, and registers load data.
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] rdata,
  output logic [1:0]  rsel,
  output logic        rvalid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // state  | meaning
  // IDLE   | no access; evaluate req_valid and alignment
  // ISSUE  | mem_req held until mem_ready
  // WAIT_R | load accepted, waiting for mem_rvalid
  // DONE   | one-cycle completion: stall released, rvalid/bus_err pulse
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sel_q;
  logic             misalign_c;
  logic             start;
  logic [3:0]       be_c;
  logic [31:0]      wd_c;

  always_comb begin
    misalign_c = 1'b0;
    be_c       = 4'b1111;
    wd_c       = req_wdata;
    case (req_size)
      2'b00: begin
        be_c = 4'b0001 << req_addr[1:0];
        wd_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misalign_c = req_addr[0];
        be_c       = 4'b0011 << req_addr[1:0];
        wd_c       = {2{req_wdata[15:0]}};
      end
      default: misalign_c = |req_addr[1:0];
    endcase
  end

  assign start    = (state == IDLE) && req_valid && !misalign_c;
  // Gated by reset so every output reads 0 while reset is held.
  assign stall    = CPU_RST_N && (start || state == ISSUE || state == WAIT_R);
  assign misalign = CPU_RST_N && (state == IDLE) && req_valid && misalign_c;
  assign mem_req  = CPU_RST_N && (state == ISSUE);

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_q     <= 2'b00;
      bus_err   <= 1'b0;
      rdata     <= '0;
      rsel      <= 2'b00;
      rvalid    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rvalid  <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            cnt       <= '0;
            sel_q     <= req_addr[1:0];
            mem_we    <= req_we;
            mem_addr  <= req_addr[31:2];
            mem_be    <= req_we ? be_c : 4'b1111;
            mem_wdata <= req_we ? wd_c : 32'h0;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            state <= mem_we ? DONE : WAIT_R;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= DONE;
            cnt     <= '0;
            bus_err <= 1'b1;
            if (!mem_we) rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            state  <= DONE;
            cnt    <= '0;
            rdata  <= mem_rdata;
            rsel   <= sel_q;
            rvalid <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state   <= DONE;
            cnt     <= '0;
            bus_err <= 1'b1;
            rdata   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: encoding vectors from a table plus
// hand-written multi-cycle sequences (wait states, timeouts, reset abort).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, misalign, bus_err, rvalid, mem_req, mem_we;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [1:0]  rsel;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic        mem_ready, mem_rvalid;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .CPU_CLK(clk), .CPU_RST_N(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .rdata(rdata), .rsel(rsel), .rvalid(rvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  // One access with immediate mem_ready and (for loads) rvalid one cycle later.
  task automatic run_vec(input vec_t v);
    tick();
    drive_req(v.we, v.size, v.addr, v.wdata);
    @(negedge clk);
    chk("idle_misalign", 32'(misalign), 32'(v.mis));
    chk("idle_stall", 32'(stall), 32'(!v.mis));
    chk("idle_mem_req", 32'(mem_req), 32'h0);
    if (v.mis) begin
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      chk("mis_no_req", 32'(mem_req), 32'h0);
      chk("mis_stall", 32'(stall), 32'h0);
      return;
    end
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("iss_mem_req", 32'(mem_req), 32'h1);
    chk("iss_stall", 32'(stall), 32'h1);
    chk("iss_mem_we", 32'(mem_we), 32'(v.we));
    chk("iss_mem_be", 32'(mem_be), 32'(v.be));
    chk("iss_mem_addr", 32'(mem_addr), 32'(v.addr >> 2));
    if (v.we) chk("iss_mem_wdata", mem_wdata, v.wd);
    tick();
    mem_ready = 1'b0;
    if (!v.we) begin
      mem_rvalid = 1'b1;
      mem_rdata  = v.rd;
      @(negedge clk);
      chk("wr_stall", 32'(stall), 32'h1);
      chk("wr_mem_req", 32'(mem_req), 32'h0);
      chk("wr_rvalid", 32'(rvalid), 32'h0);
      tick();
      mem_rvalid = 1'b0;
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("done_stall", 32'(stall), 32'h0);
    chk("done_rvalid", 32'(rvalid), 32'(!v.we));
    chk("done_bus_err", 32'(bus_err), 32'h0);
    if (!v.we) begin
      chk("done_rdata", rdata, v.rd);
      chk("done_rsel", 32'(rsel), 32'(v.addr[1:0]));
    end
    tick();
    @(negedge clk);
    chk("post_rvalid", 32'(rvalid), 32'h0);
    chk("post_stall", 32'(stall), 32'h0);
  endtask

  initial begin
    //         we    size   addr          wdata         rd            mis   be       wd
    vecs[0]  = '{1'b1, 2'b00, 32'h0000_0203, 32'h0000_00A5, 32'h0,        1'b0, 4'b1000, 32'hA5A5_A5A5};
    vecs[1]  = '{1'b1, 2'b01, 32'h0000_0202, 32'h0000_1234, 32'h0,        1'b0, 4'b1100, 32'h1234_1234};
    vecs[2]  = '{1'b1, 2'b10, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,        1'b0, 4'b1111, 32'hCAFE_F00D};
    vecs[3]  = '{1'b1, 2'b00, 32'h0000_0200, 32'hFFFF_FF3C, 32'h0,        1'b0, 4'b0001, 32'h3C3C_3C3C};
    vecs[4]  = '{1'b1, 2'b01, 32'h0000_0201, 32'h0000_5678, 32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[5]  = '{1'b0, 2'b10, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0};
    vecs[6]  = '{1'b0, 2'b10, 32'h0000_0101, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[7]  = '{1'b0, 2'b00, 32'h0000_0107, 32'h0,         32'h1122_3344, 1'b0, 4'b1111, 32'h0};
    vecs[8]  = '{1'b1, 2'b11, 32'h0000_0010, 32'h5566_7788, 32'h0,        1'b0, 4'b1111, 32'h5566_7788};
    vecs[9]  = '{1'b0, 2'b01, 32'hF000_010A, 32'h0,         32'h8765_4321, 1'b0, 4'b1111, 32'h0};
    vecs[10] = '{1'b1, 2'b11, 32'h0000_0002, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rsel", 32'(rsel), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // SB with two wait cycles: request must stay stable until accepted.
    tick();
    drive_req(1'b1, 2'b00, 32'h0000_0203, 32'h0000_00A5);
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_ready = (i == 2);
      @(negedge clk);
      chk("sbw_mem_req", 32'(mem_req), 32'h1);
      chk("sbw_stall", 32'(stall), 32'h1);
      chk("sbw_mem_we", 32'(mem_we), 32'h1);
      chk("sbw_mem_be", 32'(mem_be), 32'(4'b1000));
      chk("sbw_mem_addr", 32'(mem_addr), 32'h80);
      chk("sbw_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    end
    tick();
    mem_ready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("sbw_done_stall", 32'(stall), 32'h0);
    chk("sbw_done_req", 32'(mem_req), 32'h0);
    chk("sbw_done_err", 32'(bus_err), 32'h0);

    // Reset during WAIT_R; a late rvalid must be ignored.
    tick();
    drive_req(1'b0, 2'b10, 32'h0000_0108, 32'h0);
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; req_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
    @(negedge clk);
    chk("rstw_stall", 32'(stall), 32'h0);
    chk("rstw_mem_req", 32'(mem_req), 32'h0);
    chk("rstw_rdata", rdata, 32'h0);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rstw_rvalid", 32'(rvalid), 32'h0);
    chk("rstw_rdata2", rdata, 32'h0);

    // ready and rvalid in the same ISSUE cycle: the early rvalid is dropped.
    tick();
    drive_req(1'b0, 2'b10, 32'h0000_0110, 32'h0);
    tick();
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("same_stall", 32'(stall), 32'h1);
    chk("same_rvalid", 32'(rvalid), 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0F0F_0F0F;
    tick();
    mem_rvalid = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("same_done_rvalid", 32'(rvalid), 32'h1);
    chk("same_done_rdata", rdata, 32'h0F0F_0F0F);
    chk("same_done_stall", 32'(stall), 32'h0);

    // Load timeout in WAIT_R (TIMEOUT=4).
    tick();
    drive_req(1'b0, 2'b10, 32'h0000_010C, 32'h0);
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_wait_stall", 32'(stall), 32'h1);
      chk("to_wait_err", 32'(bus_err), 32'h0);
      tick();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("to_bus_err", 32'(bus_err), 32'h1);
    chk("to_rvalid", 32'(rvalid), 32'h0);
    chk("to_rdata", rdata, 32'h0);
    chk("to_stall", 32'(stall), 32'h0);
    tick();
    @(negedge clk);
    chk("to_idle_err", 32'(bus_err), 32'h0);
    chk("to_idle_req", 32'(mem_req), 32'h0);

    // Store timeout in ISSUE: never accepted.
    tick();
    drive_req(1'b1, 2'b10, 32'h0000_0400, 32'h1357_9BDF);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sto_req", 32'(mem_req), 32'h1);
      chk("sto_err", 32'(bus_err), 32'h0);
      tick();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("sto_bus_err", 32'(bus_err), 32'h1);
    chk("sto_done_req", 32'(mem_req), 32'h0);
    chk("sto_done_stall", 32'(stall), 32'h0);
    chk("sto_rvalid", 32'(rvalid), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
